cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_ctrl -- instruction-cycle controller for a small accumulator CPU.
//
// Sequences one eight-step instruction cycle (S0..S7) from IDLE and drives the
// datapath strobes for each step. There is also a sticky HALT state. Every
// output is registered: it is decoded from the next state, so each strobe is
// high for exactly the cycle the FSM spends in the matching state, and it
// cannot glitch.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset (forces IDLE, outputs 0)
//   ena          in   run enable, sampled in IDLE and S7 only
//   opcode[2:0]  in   instruction opcode, stable from S3 through S7
//   zero         in   accumulator-zero flag, captured at the end of S4
//   fetch        out  1 = PC drives the address bus, 0 = operand address
//   rd           out  memory/port read strobe
//   wr           out  memory/port write strobe
//   load_ir      out  instruction register byte load
//   inc_pc       out  program counter increment
//   load_pc      out  program counter load from the operand address
//   load_acc     out  accumulator load from the ALU
//   datactl_ena  out  drive the accumulator onto the data bus
//   halt         out  processor halted
// -----------------------------------------------------------------------------
module cpu_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       fetch,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       halt
);

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic fetch;
    logic rd;
    logic wr;
    logic load_ir;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic datactl_ena;
    logic halt;
  } ctrl_t;

  state_t state, state_next;
  ctrl_t  ctrl_q, ctrl_d;
  logic   zero_q;
  logic   zero_use;
  logic   is_mem_read;

  // ALU-class and load instructions all read their operand from memory.
  assign is_mem_read = (opcode == OP_ADD)  || (opcode == OP_ANDD) ||
                       (opcode == OP_XORR) || (opcode == OP_LDA);

  // The zero flag belongs to the value sampled at the end of S4. When the
  // S5 outputs are decoded on that same edge the register has not updated
  // yet, so the live input is used. S6 is decoded from the held copy, which
  // is why later changes on zero have no effect.
  assign zero_use = (state == ST_S4) ? zero : zero_q;

  // ---------------------------------------------------------------------------
  // State, latched zero and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, whatever order the statements run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ctrl_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state  <= state_next;
      ctrl_q <= ctrl_d;
      if (state == ST_S4) begin
        zero_q <= zero;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: state_next = ena ? ST_S0 : ST_IDLE;
      ST_S0:   state_next = ST_S1;
      ST_S1:   state_next = ST_S2;
      ST_S2:   state_next = ST_S3;
      ST_S3:   state_next = (opcode == OP_HLT) ? ST_HALT : ST_S4;
      ST_S4:   state_next = ST_S5;
      ST_S5:   state_next = ST_S6;
      ST_S6:   state_next = ST_S7;
      // A dropped ena only takes effect once the instruction is complete.
      ST_S7:   state_next = ena ? ST_S0 : ST_IDLE;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state. The result is registered, so the
  // outputs line up with the state the FSM is about to enter.
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d = '0;
    unique case (state_next)
      ST_S0: begin
        ctrl_d.fetch   = 1'b1;
        ctrl_d.rd      = 1'b1;
        ctrl_d.load_ir = 1'b1;
      end
      ST_S1: begin
        ctrl_d.fetch  = 1'b1;
        ctrl_d.inc_pc = 1'b1;
      end
      ST_S2: begin
        ctrl_d.fetch   = 1'b1;
        ctrl_d.rd      = 1'b1;
        ctrl_d.load_ir = 1'b1;
      end
      ST_S3: begin
        ctrl_d.fetch  = 1'b1;
        // A halting instruction does not advance past itself.
        ctrl_d.inc_pc = (opcode != OP_HLT);
      end
      ST_S4: begin
        ctrl_d.rd          = is_mem_read;
        ctrl_d.datactl_ena = (opcode == OP_STO);
        ctrl_d.load_pc     = (opcode == OP_JMP);
      end
      ST_S5: begin
        ctrl_d.rd          = is_mem_read;
        ctrl_d.load_acc    = is_mem_read;
        ctrl_d.datactl_ena = (opcode == OP_STO);
        ctrl_d.wr          = (opcode == OP_STO);
        ctrl_d.load_pc     = (opcode == OP_JMP);
        ctrl_d.inc_pc      = (opcode == OP_SKZ) && zero_use;
      end
      ST_S6: begin
        ctrl_d.datactl_ena = (opcode == OP_STO);
        ctrl_d.inc_pc      = (opcode == OP_SKZ) && zero_use;
      end
      ST_HALT: begin
        ctrl_d.halt = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  assign fetch       = ctrl_q.fetch;
  assign rd          = ctrl_q.rd;
  assign wr          = ctrl_q.wr;
  assign load_ir     = ctrl_q.load_ir;
  assign inc_pc      = ctrl_q.inc_pc;
  assign load_pc     = ctrl_q.load_pc;
  assign load_acc    = ctrl_q.load_acc;
  assign datactl_ena = ctrl_q.datactl_ena;
  assign halt        = ctrl_q.halt;

endmodule

// File: tb/tb_cpu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_ctrl -- directed self-checking bench for cpu_ctrl.
// Inputs change just after the falling edge and outputs are sampled at the
// falling edge. Output vectors are packed as
//   {fetch, rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt}.
// -----------------------------------------------------------------------------
module tb_cpu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       fetch, rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010,
                         LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  // Expected output vectors, bit order as in the header.
  localparam logic [8:0] V_ZERO  = 9'b000000000;
  localparam logic [8:0] V_FRD   = 9'b110100000; // fetch, rd, load_ir
  localparam logic [8:0] V_FINC  = 9'b100010000; // fetch, inc_pc
  localparam logic [8:0] V_F     = 9'b100000000; // fetch only
  localparam logic [8:0] V_RD    = 9'b010000000;
  localparam logic [8:0] V_RDACC = 9'b010000100; // rd, load_acc
  localparam logic [8:0] V_DEN   = 9'b000000010;
  localparam logic [8:0] V_WRDEN = 9'b001000010; // wr, datactl_ena
  localparam logic [8:0] V_LPC   = 9'b000001000;
  localparam logic [8:0] V_INC   = 9'b000010000;
  localparam logic [8:0] V_HALT  = 9'b000000001;

  cpu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .opcode      (opcode),
    .zero        (zero),
    .fetch       (fetch),
    .rd          (rd),
    .wr          (wr),
    .load_ir     (load_ir),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {fetch, rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt};
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Wait for the next falling edge and compare the output vector.
  task automatic step(input string tag, input logic [8:0] exp);
    @(negedge clk);
    check(tag, outs(), exp);
    total++;
    assert (!(rd && wr))
    else begin
      bad++;
      $error("FAIL %s_rdwr observed=rd%b,wr%b expected=not both", tag, rd, wr);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    opcode = LDA;
    zero   = 1'b0;

    // Reset state and holding in IDLE while ena is low.
    #1 check("reset", outs(), V_ZERO);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    step("idle_a", V_ZERO);
    step("idle_b", V_ZERO);

    // LDA: full eight-step cycle from IDLE, then back to IDLE.
    ena = 1'b1;
    step("lda_s0", V_FRD);
    step("lda_s1", V_FINC);
    step("lda_s2", V_FRD);
    step("lda_s3", V_FINC);
    step("lda_s4", V_RD);
    step("lda_s5", V_RDACC);
    step("lda_s6", V_ZERO);
    step("lda_s7", V_ZERO);
    ena = 1'b0;
    step("lda_idle", V_ZERO);

    // STO: ena stays high through S7, so the next instruction follows at once.
    opcode = STO;
    ena    = 1'b1;
    step("sto_s0", V_FRD);
    step("sto_s1", V_FINC);
    step("sto_s2", V_FRD);
    step("sto_s3", V_FINC);
    step("sto_s4", V_DEN);
    step("sto_s5", V_WRDEN);
    step("sto_s6", V_DEN);
    step("sto_s7", V_ZERO);
    opcode = SKZ;

    // SKZ with zero=1 at the end of S4, then dropped: skip is still taken.
    step("skz1_s0", V_FRD);
    step("skz1_s1", V_FINC);
    step("skz1_s2", V_FRD);
    step("skz1_s3", V_FINC);
    step("skz1_s4", V_ZERO);
    zero = 1'b1;
    step("skz1_s5", V_INC);
    zero = 1'b0;
    step("skz1_s6", V_INC);
    step("skz1_s7", V_ZERO);

    // SKZ with zero=0 at the end of S4, then raised: no skip.
    step("skz0_s0", V_FRD);
    step("skz0_s1", V_FINC);
    step("skz0_s2", V_FRD);
    step("skz0_s3", V_FINC);
    step("skz0_s4", V_ZERO);
    step("skz0_s5", V_ZERO);
    zero = 1'b1;
    step("skz0_s6", V_ZERO);
    step("skz0_s7", V_ZERO);
    opcode = JMP;
    zero   = 1'b0;

    // JMP with ena dropped during S2: instruction completes, then IDLE.
    step("jmp_s0", V_FRD);
    step("jmp_s1", V_FINC);
    step("jmp_s2", V_FRD);
    ena = 1'b0;
    step("jmp_s3", V_FINC);
    step("jmp_s4", V_LPC);
    step("jmp_s5", V_LPC);
    step("jmp_s6", V_ZERO);
    step("jmp_s7", V_ZERO);
    step("jmp_idle_a", V_ZERO);
    step("jmp_idle_b", V_ZERO);

    // ADD with an asynchronous reset pulse in the middle of S5.
    opcode = ADD;
    ena    = 1'b1;
    step("add_s0", V_FRD);
    step("add_s1", V_FINC);
    step("add_s2", V_FRD);
    step("add_s3", V_FINC);
    step("add_s4", V_RD);
    step("add_s5", V_RDACC);
    #2 rst_n = 1'b0;
    #1 check("add_async_rst", outs(), V_ZERO);
    ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("add_idle", V_ZERO);
    ena = 1'b1;
    step("add2_s0", V_FRD);
    step("add2_s1", V_FINC);
    step("add2_s2", V_FRD);
    step("add2_s3", V_FINC);
    step("add2_s4", V_RD);
    step("add2_s5", V_RDACC);
    step("add2_s6", V_ZERO);
    opcode = HLT;
    ena    = 1'b0;
    step("add2_s7", V_ZERO);
    step("add2_idle", V_ZERO);

    // HLT: no inc_pc in S3, then HALT held for 20 cycles while ena toggles.
    ena = 1'b1;
    step("hlt_s0", V_FRD);
    step("hlt_s1", V_FINC);
    step("hlt_s2", V_FRD);
    step("hlt_s3", V_F);
    for (int i = 0; i < 20; i++) begin
      ena = i[0];
      step($sformatf("halt_%0d", i), V_HALT);
    end
    #2 rst_n = 1'b0;
    #1 check("halt_async_rst", outs(), V_ZERO);
    ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_halt_idle", V_ZERO);
    ena = 1'b1;
    step("post_halt_s0", V_FRD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
